// File: rtl/sdio_cmd_engine.sv
// sdio_cmd_engine
// Card-side SD/SDIO command-line engine. It receives 48-bit host command
// frames on CMD and checks the framing bits, the CRC7 and a per-index
// legality mask. Legal commands are presented on cmd_index/cmd_arg with a
// one-cycle cmd_valid pulse. After that the engine waits, with a bounded
// timeout, for the function logic to offer a response. It then releases CMD
// for NCR_CYCLES cycles and serialises a 48-bit short frame or a 136-bit
// long (R2) frame.
//
// Parameters
//   TIMEOUT_W  : width of the response-wait counter (timeout after 2^W-1 cycles)
//   NCR_CYCLES : released cycles between response accept and start bit (2..64)
//   CMD_MASK   : bit n set means command index n is legal
//
// Ports
//   sd_clk, sd_rst_n         : card clock, synchronous active-low reset
//   sd_cmd                   : sampled CMD line
//   sd_cmd_out, sd_cmd_dir   : CMD drive value and drive enable (1 = drive)
//   cmd_index, cmd_arg       : decoded command, valid while cmd_valid
//   cmd_valid                : pulse, legal CRC-clean command received
//   rsp_ready                : high while a response may be accepted
//   rsp_valid, rsp_type      : response offer (00/11 none, 01 short, 10 long)
//   rsp_data                 : short {index, payload} in [37:0]; long CID/CSD in [119:0]
//   crc_error, frame_error,
//   illegal_cmd, timeout_error : one-cycle error pulses
module sdio_cmd_engine #(
    parameter int unsigned TIMEOUT_W  = 16,
    parameter int unsigned NCR_CYCLES = 2,
    parameter logic [63:0] CMD_MASK   = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic         sd_clk,
    input  logic         sd_rst_n,
    input  logic         sd_cmd,
    output logic         sd_cmd_out,
    output logic         sd_cmd_dir,
    output logic [5:0]   cmd_index,
    output logic [31:0]  cmd_arg,
    output logic         cmd_valid,
    output logic         rsp_ready,
    input  logic         rsp_valid,
    input  logic [1:0]   rsp_type,
    input  logic [119:0] rsp_data,
    output logic         crc_error,
    output logic         frame_error,
    output logic         illegal_cmd,
    output logic         timeout_error
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RX       = 3'd1,
        CHECK    = 3'd2,
        WAIT_RSP = 3'd3,
        NCR      = 3'd4,
        TX       = 3'd5
    } state_t;

    localparam logic [6:0] NCR_LAST  = 7'(NCR_CYCLES);
    localparam logic [7:0] SHORT_LEN = 8'd48;
    localparam logic [7:0] LONG_LEN  = 8'd136;

    // One serial CRC7 step, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        crc7_step = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // CRC7 over the 40 header bits of a short response, MSB first.
    function automatic logic [6:0] crc7_short(input logic [39:0] d);
        logic [6:0] c;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            c = crc7_step(c, d[i]);
        end
        crc7_short = c;
    endfunction

    // CRC7 over the 120 CID/CSD bits of a long response, MSB first.
    function automatic logic [6:0] crc7_long(input logic [119:0] d);
        logic [6:0] c;
        c = 7'h00;
        for (int i = 119; i >= 0; i--) begin
            c = crc7_step(c, d[i]);
        end
        crc7_long = c;
    endfunction

    state_t                 state_r;
    state_t                 next_s;

    logic [46:0]            rx_sr_r;     // frame bits 46..0, bit 46 ends up at [46]
    logic [5:0]             rx_cnt_r;    // bits received so far in RX
    logic [6:0]             crc_r;       // running CRC over frame bits 47..8
    logic [TIMEOUT_W-1:0]   tmo_cnt_r;
    logic [6:0]             ncr_cnt_r;
    logic [135:0]           tx_sr_r;     // outgoing frame, MSB is next bit
    logic [7:0]             tx_len_r;
    logic [7:0]             tx_left_r;   // bits still to drive after the current one

    logic                   cmd_out_r;
    logic                   cmd_dir_r;
    logic [5:0]             cmd_index_r;
    logic [31:0]            cmd_arg_r;
    logic                   cmd_valid_r;
    logic                   rsp_ready_r;
    logic                   crc_error_r;
    logic                   frame_error_r;
    logic                   illegal_cmd_r;
    logic                   timeout_error_r;

    logic                   frame_bad_s;
    logic                   crc_bad_s;
    logic                   illegal_s;
    logic                   accept_s;
    logic                   tmo_term_s;
    logic                   rsp_short_s;
    logic                   rsp_long_s;

    assign sd_cmd_out    = cmd_out_r;
    assign sd_cmd_dir    = cmd_dir_r;
    assign cmd_index     = cmd_index_r;
    assign cmd_arg       = cmd_arg_r;
    assign cmd_valid     = cmd_valid_r;
    assign rsp_ready     = rsp_ready_r;
    assign crc_error     = crc_error_r;
    assign frame_error   = frame_error_r;
    assign illegal_cmd   = illegal_cmd_r;
    assign timeout_error = timeout_error_r;

    // Decode of the captured frame and of the response handshake.
    always_comb begin
        frame_bad_s = ~rx_sr_r[46] | ~rx_sr_r[0];
        crc_bad_s   = (rx_sr_r[7:1] != crc_r);
        illegal_s   = ~CMD_MASK[rx_sr_r[45:40]];
        accept_s    = rsp_valid & rsp_ready_r;
        tmo_term_s  = &tmo_cnt_r;
        rsp_short_s = (rsp_type == 2'b01);
        rsp_long_s  = (rsp_type == 2'b10);
    end

    // Next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!sd_cmd) begin
                    next_s = RX;
                end else begin
                    next_s = IDLE;
                end
            end
            RX: begin
                if (rx_cnt_r == 6'd46) begin
                    next_s = CHECK;
                end else begin
                    next_s = RX;
                end
            end
            CHECK: begin
                if (frame_bad_s || crc_bad_s || illegal_s) begin
                    next_s = IDLE;
                end else begin
                    next_s = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // Accept takes priority over a coincident terminal count.
                if (accept_s) begin
                    if (rsp_short_s || rsp_long_s) begin
                        next_s = NCR;
                    end else begin
                        next_s = IDLE;
                    end
                end else if (tmo_term_s) begin
                    next_s = IDLE;
                end else begin
                    next_s = WAIT_RSP;
                end
            end
            NCR: begin
                if (ncr_cnt_r == NCR_LAST) begin
                    next_s = TX;
                end else begin
                    next_s = NCR;
                end
            end
            TX: begin
                if (tx_left_r == 8'd0) begin
                    next_s = IDLE;
                end else begin
                    next_s = TX;
                end
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge sd_clk) begin
        if (!sd_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge sd_clk) begin
        if (!sd_rst_n) begin
            rx_sr_r         <= 47'd0;
            rx_cnt_r        <= 6'd0;
            crc_r           <= 7'd0;
            tmo_cnt_r       <= '0;
            ncr_cnt_r       <= 7'd0;
            tx_sr_r         <= 136'd0;
            tx_len_r        <= 8'd0;
            tx_left_r       <= 8'd0;
            cmd_out_r       <= 1'b1;
            cmd_dir_r       <= 1'b0;
            cmd_index_r     <= 6'd0;
            cmd_arg_r       <= 32'd0;
            cmd_valid_r     <= 1'b0;
            rsp_ready_r     <= 1'b0;
            crc_error_r     <= 1'b0;
            frame_error_r   <= 1'b0;
            illegal_cmd_r   <= 1'b0;
            timeout_error_r <= 1'b0;
        end else begin
            cmd_valid_r     <= 1'b0;
            crc_error_r     <= 1'b0;
            frame_error_r   <= 1'b0;
            illegal_cmd_r   <= 1'b0;
            timeout_error_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // The start bit is zero, so it leaves the CRC at its initial zero.
                    if (!sd_cmd) begin
                        rx_cnt_r <= 6'd0;
                        crc_r    <= 7'd0;
                    end
                end
                RX: begin
                    rx_sr_r  <= {rx_sr_r[45:0], sd_cmd};
                    rx_cnt_r <= rx_cnt_r + 6'd1;
                    // Count k carries frame bit 46-k; the CRC covers down to bit 8.
                    if (rx_cnt_r <= 6'd38) begin
                        crc_r <= crc7_step(crc_r, sd_cmd);
                    end
                end
                CHECK: begin
                    tmo_cnt_r <= '0;
                    if (frame_bad_s) begin
                        frame_error_r <= 1'b1;
                    end else if (crc_bad_s) begin
                        crc_error_r <= 1'b1;
                    end else if (illegal_s) begin
                        illegal_cmd_r <= 1'b1;
                    end else begin
                        cmd_valid_r <= 1'b1;
                        cmd_index_r <= rx_sr_r[45:40];
                        cmd_arg_r   <= rx_sr_r[39:8];
                    end
                end
                WAIT_RSP: begin
                    if (accept_s) begin
                        rsp_ready_r <= 1'b0;
                        ncr_cnt_r   <= 7'd0;
                        if (rsp_long_s) begin
                            tx_sr_r  <= {2'b00, 6'b111111, rsp_data,
                                         crc7_long(rsp_data), 1'b1};
                            tx_len_r <= LONG_LEN;
                        end else begin
                            tx_sr_r  <= {2'b00, rsp_data[37:0],
                                         crc7_short({2'b00, rsp_data[37:0]}),
                                         1'b1, 88'd0};
                            tx_len_r <= SHORT_LEN;
                        end
                    end else if (tmo_term_s) begin
                        rsp_ready_r     <= 1'b0;
                        timeout_error_r <= 1'b1;
                    end else begin
                        rsp_ready_r <= 1'b1;
                        tmo_cnt_r   <= tmo_cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
                    end
                end
                NCR: begin
                    if (ncr_cnt_r == NCR_LAST) begin
                        cmd_dir_r <= 1'b1;
                        cmd_out_r <= tx_sr_r[135];
                        tx_sr_r   <= {tx_sr_r[134:0], 1'b0};
                        tx_left_r <= tx_len_r - 8'd1;
                    end else begin
                        ncr_cnt_r <= ncr_cnt_r + 7'd1;
                    end
                end
                TX: begin
                    if (tx_left_r != 8'd0) begin
                        cmd_out_r <= tx_sr_r[135];
                        tx_sr_r   <= {tx_sr_r[134:0], 1'b0};
                        tx_left_r <= tx_left_r - 8'd1;
                    end else begin
                        cmd_dir_r <= 1'b0;
                        cmd_out_r <= 1'b1;
                    end
                end
                default: begin
                    cmd_dir_r <= 1'b0;
                    cmd_out_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdio_cmd_engine.sv
// Bench for sdio_cmd_engine: directed host frames and responses, with a
// cycle-indexed expectation model checked on every falling edge.
module tb_sdio_cmd_engine;

    localparam int          NCR  = 2;
    localparam int          TW   = 4;
    localparam logic [63:0] MASK = 64'hFFFF_FFFF_FFFF_FFDF;   // CMD5 illegal

    localparam int K_NONE = 0, K_VALID = 1, K_FRAME = 2, K_CRC = 3, K_ILL = 4, K_TMO = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sd_cmd;
    logic         sd_cmd_out, sd_cmd_dir;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic         cmd_valid, rsp_ready, rsp_valid;
    logic [1:0]   rsp_type;
    logic [119:0] rsp_data;
    logic         crc_error, frame_error, illegal_cmd, timeout_error;

    sdio_cmd_engine #(.TIMEOUT_W(TW), .NCR_CYCLES(NCR), .CMD_MASK(MASK)) dut (
        .sd_clk(clk), .sd_rst_n(rst_n), .sd_cmd(sd_cmd),
        .sd_cmd_out(sd_cmd_out), .sd_cmd_dir(sd_cmd_dir),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_valid(cmd_valid),
        .rsp_ready(rsp_ready), .rsp_valid(rsp_valid), .rsp_type(rsp_type),
        .rsp_data(rsp_data), .crc_error(crc_error), .frame_error(frame_error),
        .illegal_cmd(illegal_cmd), .timeout_error(timeout_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Expectation model: outcome pulses keyed by cycle, plus windows.
    int           exp_evt[int];
    logic [5:0]   exp_idx;
    logic [31:0]  exp_arg;
    int           rdy_lo = -1, rdy_hi = -2;
    int           tx_lo = -1, tx_hi = -2, tx_len = 0;
    logic [135:0] exp_tx;
    bit           chk_en = 1'b0;

    logic [135:0] cap = '0;
    int           cap_n = 0;
    int           tmo_seen = -1;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [119:0] d, input int n);
        logic [6:0] c;
        logic fb;
        c = 7'h00;
        for (int i = n - 1; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] h;
        h = {2'b01, idx, arg};
        return {h, crc7({80'd0, h}, 40), 1'b1};
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        int  k;
        logic edir, eout;
        if (chk_en) begin
            k = exp_evt.exists(cyc) ? exp_evt[cyc] : K_NONE;
            check("cmd_valid", {135'd0, cmd_valid}, {135'd0, k == K_VALID});
            check("frame_error", {135'd0, frame_error}, {135'd0, k == K_FRAME});
            check("crc_error", {135'd0, crc_error}, {135'd0, k == K_CRC});
            check("illegal_cmd", {135'd0, illegal_cmd}, {135'd0, k == K_ILL});
            check("timeout_error", {135'd0, timeout_error}, {135'd0, k == K_TMO});
            if (k == K_VALID) begin
                check("cmd_index", {130'd0, cmd_index}, {130'd0, exp_idx});
                check("cmd_arg", {104'd0, cmd_arg}, {104'd0, exp_arg});
            end
            check("rsp_ready", {135'd0, rsp_ready}, {135'd0, (cyc >= rdy_lo) && (cyc <= rdy_hi)});
            edir = (cyc >= tx_lo) && (cyc <= tx_hi);
            eout = edir ? exp_tx[tx_len - 1 - (cyc - tx_lo)] : 1'b1;
            check("sd_cmd_dir", {135'd0, sd_cmd_dir}, {135'd0, edir});
            check("sd_cmd_out", {135'd0, sd_cmd_out}, {135'd0, eout});
            if (sd_cmd_dir === 1'b1) begin
                cap   <= {cap[134:0], sd_cmd_out};
                cap_n <= cap_n + 1;
            end
            if (timeout_error === 1'b1) tmo_seen <= cyc;
        end
    end

    task automatic wait_cyc(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc < target) check("wait_bound", 136'(cyc), 136'(target));
    endtask

    // Drives a host frame; t returns the edge at which the start bit is sampled.
    task automatic send_frame(input logic [47:0] f, output int t);
        int kind;
        t = cyc + 1;
        if (!f[46] || !f[0])                     kind = K_FRAME;
        else if (f[7:1] != crc7({80'd0, f[47:8]}, 40)) kind = K_CRC;
        else if (!MASK[f[45:40]])                kind = K_ILL;
        else                                     kind = K_VALID;
        exp_evt[t + 48] = kind;
        if (kind == K_VALID) begin
            exp_idx = f[45:40];
            exp_arg = f[39:8];
            rdy_lo  = t + 49;
            rdy_hi  = t + 49 + (2 ** TW - 1) - 1;
            exp_evt[t + 49 + (2 ** TW - 1)] = K_TMO;
        end
        for (int i = 47; i >= 0; i--) begin
            sd_cmd = f[i];
            @(posedge clk);
            #1;
        end
        sd_cmd = 1'b1;
    endtask

    // Offers a response so it is accepted at edge t+51; a returns that edge.
    task automatic respond(input int t, input logic [1:0] typ, input logic [119:0] d, output int a);
        wait_cyc(t + 50);
        rsp_valid = 1'b1;
        rsp_type  = typ;
        rsp_data  = d;
        a = cyc + 1;
        rdy_hi = a - 1;
        exp_evt.delete(t + 49 + (2 ** TW - 1));
        if (typ == 2'b01) begin
            tx_len = 48;
            exp_tx = {88'd0, 2'b00, d[37:0], crc7({82'd0, d[37:0]}, 40), 1'b1};
        end else if (typ == 2'b10) begin
            tx_len = 136;
            exp_tx = {2'b00, 6'b111111, d, crc7(d, 120), 1'b1};
        end else begin
            tx_len = 0;
        end
        if (tx_len != 0) begin
            tx_lo = a + 1 + NCR;
            tx_hi = tx_lo + tx_len - 1;
        end
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
    endtask

    initial begin
        int t, a, c0;
        logic [119:0] longd;

        rst_n = 1'b0; sd_cmd = 1'b1; rsp_valid = 1'b0; rsp_type = 2'b00; rsp_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dir", {135'd0, sd_cmd_dir}, 136'd0);
        check("rst_out", {135'd0, sd_cmd_out}, 136'd1);
        check("rst_ready", {135'd0, rsp_ready}, 136'd0);
        check("rst_index", {130'd0, cmd_index}, 136'd0);
        check("rst_arg", {104'd0, cmd_arg}, 136'd0);
        check("rst_pulses", {132'd0, cmd_valid, crc_error, frame_error, illegal_cmd}, 136'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Model pins against hand-known CRC7 values.
        check("crc_cmd0", {129'd0, crc7(120'h40_0000_0000, 40)}, {129'd0, 7'h4A});
        check("crc_cmd8", {129'd0, crc7(120'h48_0000_01AA, 40)}, {129'd0, 7'h43});
        check("crc_r1_55", {129'd0, crc7(120'h37_0000_0120, 40)}, {129'd0, 7'h41});

        // Valid CMD0, no response.
        c0 = cap_n;
        send_frame(48'h40_0000_0000_95, t);
        respond(t, 2'b00, 120'd0, a);
        wait_cyc(a + 8);
        check("cmd0_no_drive", 136'(cap_n - c0), 136'd0);

        // Valid CMD8, type 11 treated as none.
        send_frame(48'h48_0000_01AA_87, t);
        respond(t, 2'b11, 120'h1234, a);
        wait_cyc(a + 8);
        check("cmd8_no_drive", 136'(cap_n - c0), 136'd0);

        // End bit cleared -> frame error; CRC corrupted back-to-back -> crc error.
        send_frame(48'h48_0000_01AA_86, t);
        wait_cyc(t + 48);
        send_frame(48'h48_0000_01AA_85, a);
        check("b2b_start", 136'(a), 136'(t + 49));
        wait_cyc(a + 52);

        // Short response to CMD55.
        send_frame(mk_cmd(6'd55, 32'h0), t);
        c0 = cap_n;
        respond(t, 2'b01, {82'd0, 6'd55, 32'h0000_0120}, a);
        check("short_start", 136'(tx_lo), 136'(a + 3));
        wait_cyc(tx_hi + 3);
        check("short_len", 136'(cap_n - c0), 136'd48);
        check("short_frame", {88'd0, cap[47:0]}, {88'd0, 48'h37_0000_0120_83});

        // Long R2 response with incrementing bytes.
        for (int k = 0; k < 15; k++) longd[119 - 8 * k -: 8] = 8'(k + 1);
        send_frame(mk_cmd(6'd2, 32'h0), t);
        c0 = cap_n;
        respond(t, 2'b10, longd, a);
        wait_cyc(tx_hi + 3);
        check("long_len", 136'(cap_n - c0), 136'd136);
        check("long_header", {128'd0, cap[135:128]}, {128'd0, 8'h3F});
        check("long_data", {16'd0, cap[127:8]}, {16'd0, longd});
        check("long_end", {135'd0, cap[0]}, 136'd1);

        // Illegal CMD5.
        send_frame(mk_cmd(6'd5, 32'h0), t);
        wait_cyc(t + 52);

        // Timeout with no response.
        send_frame(mk_cmd(6'd8, 32'h1AA), t);
        wait_cyc(t + 68);
        check("timeout_cycle", 136'(tmo_seen), 136'(t + 49 + 15));

        // Reset at bit 20 of a long response.
        send_frame(mk_cmd(6'd2, 32'h0), t);
        respond(t, 2'b10, longd, a);
        wait_cyc(tx_lo + 20);
        rst_n = 1'b0;
        tx_hi = tx_lo + 20;
        @(posedge clk);
        #1;
        check("rst_tx_dir", {135'd0, sd_cmd_dir}, 136'd0);
        check("rst_tx_out", {135'd0, sd_cmd_out}, 136'd1);
        check("rst_tx_index", {130'd0, cmd_index}, 136'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // CMD0 after reset.
        send_frame(48'h40_0000_0000_95, t);
        respond(t, 2'b00, 120'd0, a);
        wait_cyc(a + 8);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
